tage_bank_sched: RTL and testbench

Port scheduler for one single-ported TAGE tagged-table bank. It sits between the fetch-stage predictor lookup and the branch-resolution update path. It arbitrates each cycle between:
- prediction reads;
- buffered update writes;
- a periodic useful-bit attenuation sweep.

Each bank sees at most one access per cycle, and updates are never lost.

---
 rtl/tage_bank_sched.sv | 192 +++++++++++++++++++
 tb/tb_tage_bank_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tage_bank_sched.sv
// Single-port TAGE bank scheduler: arbitrates prediction reads, buffered update
// writes and a periodic useful-bit attenuation sweep onto one registered bank port.
module tage_bank_sched #(
    parameter int DEPTH    = 128,
    parameter int PW       = 7,
    parameter int DATAW    = 9,
    parameter int FIFODEEP = 4,
    parameter int ATTW     = 18
) (
    input  logic             Clk_i,
    input  logic             Rest_i,
    input  logic             RdReq_i,
    input  logic [PW-1:0]    RdAddr_i,
    output logic             RdReady_o,
    input  logic             UpReq_i,
    input  logic [PW-1:0]    UpAddr_i,
    input  logic [DATAW-1:0] UpData_i,
    output logic             UpReady_o,
    output logic             BankEn_o,
    output logic             BankWe_o,
    output logic [PW-1:0]    BankAddr_o,
    output logic [DATAW-1:0] BankDin_o,
    output logic             BankUClr_o,
    output logic             SweepBusy_o
);

    localparam int QW = $clog2(FIFODEEP);
    localparam int CW = QW + 1;
    localparam int EW = PW + DATAW;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    sweepPtr_q, sweepPtr_d;
    logic             sweepPend_q, sweepPend_d;
    logic [ATTW-1:0]  attCnt_q, attCnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [QW-1:0]    rdPtr_q, rdPtr_d;
    logic [QW-1:0]    wrPtr_q, wrPtr_d;
    logic [EW-1:0]    fifoMem_q [FIFODEEP];

    logic             bankEn_q, bankEn_d;
    logic             bankWe_q, bankWe_d;
    logic [PW-1:0]    bankAddr_q, bankAddr_d;
    logic [DATAW-1:0] bankDin_q, bankDin_d;
    logic             bankUClr_q, bankUClr_d;

    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             grantHead;
    logic             grantRead;
    logic             grantSweep;
    logic             attWrap;
    logic [EW-1:0]    headEntry;

    assign fifoFull  = (count_q == CW'(FIFODEEP));
    assign fifoEmpty = (count_q == '0);
    assign headEntry = fifoMem_q[rdPtr_q];

    // Readies are gated by reset so nothing is accepted while the block is held.
    assign UpReady_o = !Rest_i && !fifoFull;
    assign RdReady_o = !Rest_i && RdReq_i && !fifoFull;
    assign push      = UpReq_i && UpReady_o;
    assign attWrap   = push && (attCnt_q == '1);

    always_comb begin
        grantHead  = 1'b0;
        grantRead  = 1'b0;
        grantSweep = 1'b0;
        if (fifoFull) begin
            grantHead = 1'b1;
        end else if (RdReq_i) begin
            grantRead = 1'b1;
        end else if (state_q == SWEEP) begin
            grantSweep = 1'b1;
        end else if (!fifoEmpty) begin
            grantHead = 1'b1;
        end
    end

    always_comb begin
        bankEn_d   = grantHead || grantRead || grantSweep;
        bankWe_d   = grantHead || grantSweep;
        bankUClr_d = grantSweep;
        bankAddr_d = '0;
        bankDin_d  = '0;
        if (grantRead) begin
            bankAddr_d = RdAddr_i;
        end else if (grantSweep) begin
            bankAddr_d = sweepPtr_q;
        end else if (grantHead) begin
            bankAddr_d = headEntry[EW-1:DATAW];
            bankDin_d  = headEntry[DATAW-1:0];
        end
    end

    always_comb begin
        count_d  = count_q;
        rdPtr_d  = rdPtr_q;
        wrPtr_d  = wrPtr_q;
        attCnt_d = attCnt_q;
        if (push) begin
            wrPtr_d  = wrPtr_q + 1'b1;
            attCnt_d = attCnt_q + 1'b1;
        end
        if (grantHead) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push && !grantHead) begin
            count_d = count_q + 1'b1;
        end else if (!push && grantHead) begin
            count_d = count_q - 1'b1;
        end
    end

    // A wrap during an active sweep stays pending and launches the next sweep from IDLE.
    always_comb begin
        state_d     = state_q;
        sweepPtr_d  = sweepPtr_q;
        sweepPend_d = sweepPend_q || attWrap;
        case (state_q)
            IDLE: begin
                if (sweepPend_q) begin
                    state_d     = SWEEP;
                    sweepPtr_d  = '0;
                    sweepPend_d = attWrap;
                end
            end
            SWEEP: begin
                if (grantSweep) begin
                    if (sweepPtr_q == PW'(DEPTH - 1)) begin
                        state_d    = IDLE;
                        sweepPtr_d = '0;
                    end else begin
                        sweepPtr_d = sweepPtr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rest_i) begin
        if (Rest_i) begin
            state_q     <= IDLE;
            sweepPtr_q  <= '0;
            sweepPend_q <= 1'b0;
            attCnt_q    <= '0;
            count_q     <= '0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            bankEn_q    <= 1'b0;
            bankWe_q    <= 1'b0;
            bankAddr_q  <= '0;
            bankDin_q   <= '0;
            bankUClr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweepPtr_q  <= sweepPtr_d;
            sweepPend_q <= sweepPend_d;
            attCnt_q    <= attCnt_d;
            count_q     <= count_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            bankEn_q    <= bankEn_d;
            bankWe_q    <= bankWe_d;
            bankAddr_q  <= bankAddr_d;
            bankDin_q   <= bankDin_d;
            bankUClr_q  <= bankUClr_d;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {UpAddr_i, UpData_i};
        end
    end

    assign BankEn_o    = bankEn_q;
    assign BankWe_o    = bankWe_q;
    assign BankAddr_o  = bankAddr_q;
    assign BankDin_o   = bankDin_q;
    assign BankUClr_o  = bankUClr_q;
    assign SweepBusy_o = (state_q == SWEEP);

endmodule

// File: tb/tb_tage_bank_sched.sv
// Scoreboard bench for tage_bank_sched on a small bank (DEPTH 8, ATTW 3) so sweeps are short.
module tb_tage_bank_sched;

    logic       Clk;
    logic       Rest;
    logic       RdReq;
    logic [2:0] RdAddr;
    logic       RdReady;
    logic       UpReq;
    logic [2:0] UpAddr;
    logic [8:0] UpData;
    logic       UpReady;
    logic       BankEn;
    logic       BankWe;
    logic [2:0] BankAddr;
    logic [8:0] BankDin;
    logic       BankUClr;
    logic       SweepBusy;

    int vectorCount = 0;
    int missCount   = 0;
    int sweepWrites = 0;
    int expSweep    = 0;

    logic [2:0]  readQ[$];
    logic [11:0] updQ[$];

    tage_bank_sched #(
        .DEPTH(8), .PW(3), .DATAW(9), .FIFODEEP(4), .ATTW(3)
    ) dut (
        .Clk_i(Clk), .Rest_i(Rest),
        .RdReq_i(RdReq), .RdAddr_i(RdAddr), .RdReady_o(RdReady),
        .UpReq_i(UpReq), .UpAddr_i(UpAddr), .UpData_i(UpData), .UpReady_o(UpReady),
        .BankEn_o(BankEn), .BankWe_o(BankWe), .BankAddr_o(BankAddr),
        .BankDin_o(BankDin), .BankUClr_o(BankUClr), .SweepBusy_o(SweepBusy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard: every bank access is matched against what the bench issued.
    always @(posedge Clk) begin
        #1;
        if (!Rest && BankEn) begin
            vectorCount++;
            if (!BankWe) begin
                if (readQ.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL unexpected_read addr=%0d", BankAddr);
                end else begin
                    logic [2:0] expA;
                    expA = readQ.pop_front();
                    if (BankAddr !== expA) begin
                        missCount++;
                        $display("[TB] FAIL read_addr got=%0d exp=%0d", BankAddr, expA);
                    end
                end
            end else if (BankUClr) begin
                if (BankAddr !== 3'(expSweep)) begin
                    missCount++;
                    $display("[TB] FAIL sweep_addr got=%0d exp=%0d", BankAddr, expSweep);
                end
                if (BankAddr == 3'd7) begin
                    vectorCount++;
                    if (SweepBusy !== 1'b0) begin
                        missCount++;
                        $display("[TB] FAIL sweep_busy_fall got=%b exp=0", SweepBusy);
                    end
                end
                expSweep = (expSweep + 1) % 8;
                sweepWrites++;
            end else begin
                if (updQ.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL unexpected_update addr=%0d din=%h", BankAddr, BankDin);
                end else begin
                    logic [11:0] expE;
                    expE = updQ.pop_front();
                    if ({BankAddr, BankDin} !== expE) begin
                        missCount++;
                        $display("[TB] FAIL update_write got=%h exp=%h", {BankAddr, BankDin}, expE);
                    end
                end
            end
        end
    end

    task automatic drive(input logic rr, input logic [2:0] ra, input logic ur,
                         input logic [2:0] ua, input logic [8:0] ud,
                         output logic rrdy, output logic acc);
        @(negedge Clk);
        RdReq  = rr;
        RdAddr = ra;
        UpReq  = ur;
        UpAddr = ua;
        UpData = ud;
        #1;
        rrdy = RdReady;
        acc  = UpReady && ur;
        if (rrdy) readQ.push_back(ra);
        if (acc) updQ.push_back({ua, ud});
    endtask

    task automatic idle();
        logic r, u;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 9'd0, r, u);
    endtask

    task automatic pushUpdates(input int n, output int accepted);
        logic r, u;
        accepted = 0;
        for (int i = 0; i < n * 8 + 20 && accepted < n; i++) begin
            drive(1'b0, 3'd0, 1'b1, 3'(accepted), 9'(9'h040 + accepted * 5), r, u);
            if (u) accepted++;
        end
        idle();
    endtask

    task automatic doReset();
        Rest   = 1'b1;
        RdReq  = 1'b0;
        RdAddr = '0;
        UpReq  = 1'b0;
        UpAddr = '0;
        UpData = '0;
        @(negedge Clk);
        @(negedge Clk);
        readQ.delete();
        updQ.delete();
        expSweep    = 0;
        sweepWrites = 0;
        Rest = 1'b0;
    endtask

    task automatic test_reset();
        Rest  = 1'b1;
        RdReq = 1'b1;
        UpReq = 1'b1;
        @(negedge Clk);
        #1;
        vectorCount++;
        if ({RdReady, UpReady} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL reset_readies got=%b exp=00", {RdReady, UpReady});
        end
        vectorCount++;
        if ({BankEn, BankWe, BankAddr, BankDin, BankUClr, SweepBusy} !== 16'd0) begin
            missCount++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {BankEn, BankWe, BankAddr, BankDin, BankUClr, SweepBusy});
        end
        RdReq = 1'b0;
        UpReq = 1'b0;
        doReset();
        #1;
        vectorCount++;
        if ({RdReady, UpReady} !== 2'b01) begin
            missCount++;
            $display("[TB] FAIL post_reset_readies got=%b exp=01", {RdReady, UpReady});
        end
    endtask

    task automatic test_read();
        logic r, u;
        doReset();
        drive(1'b1, 3'd5, 1'b0, 3'd0, 9'd0, r, u);
        vectorCount++;
        if (r !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL read_ready got=%b exp=1", r);
        end
        @(posedge Clk);
        #1;
        vectorCount++;
        if ({BankEn, BankWe, BankAddr} !== {1'b1, 1'b0, 3'd5}) begin
            missCount++;
            $display("[TB] FAIL read_issue got=%b%b%0d exp=1 0 5", BankEn, BankWe, BankAddr);
        end
        idle();
    endtask

    task automatic test_update();
        logic r, u;
        doReset();
        drive(1'b0, 3'd0, 1'b1, 3'd3, 9'h1A5, r, u);
        vectorCount++;
        if (u !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL up_ready got=%b exp=1", u);
        end
        @(posedge Clk);
        #1;
        vectorCount++;
        if (BankEn !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL no_bypass got=%b exp=0", BankEn);
        end
        idle();
        @(posedge Clk);
        #1;
        vectorCount++;
        if ({BankEn, BankWe, BankAddr, BankDin, BankUClr} !== {1'b1, 1'b1, 3'd3, 9'h1A5, 1'b0}) begin
            missCount++;
            $display("[TB] FAIL update_issue got=%b%b a=%0d d=%h u=%b exp=11 a=3 d=1a5 u=0",
                     BankEn, BankWe, BankAddr, BankDin, BankUClr);
        end
    endtask

    task automatic test_back_to_back();
        logic r, u;
        logic [2:0] rdA;
        int idx;
        logic tried4;
        doReset();
        idx    = 0;
        rdA    = 3'd0;
        tried4 = 1'b0;
        for (int it = 0; it < 40 && idx < 5; it++) begin
            drive(1'b1, rdA, 1'b1, 3'(idx + 1), 9'(9'h0A0 + idx * 17), r, u);
            if (idx == 4 && !tried4) begin
                tried4 = 1'b1;
                vectorCount++;
                if ({u, r} !== 2'b00) begin
                    missCount++;
                    $display("[TB] FAIL full_offer up/rd ready got=%b exp=00", {u, r});
                end
            end
            if (r) rdA = rdA + 3'd1;
            if (u) idx++;
        end
        vectorCount++;
        if (idx != 5) begin
            missCount++;
            $display("[TB] FAIL b2b_accepted got=%0d exp=5", idx);
        end
        idle();
        for (int i = 0; i < 30 && (updQ.size() != 0 || readQ.size() != 0); i++) @(negedge Clk);
        vectorCount++;
        if (updQ.size() != 0 || readQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL b2b_drain pending upd=%0d rd=%0d exp=0", updQ.size(), readQ.size());
        end
    endtask

    task automatic test_sweep();
        int acc;
        doReset();
        pushUpdates(8, acc);
        vectorCount++;
        if (acc != 8) begin
            missCount++;
            $display("[TB] FAIL sweep_pushes got=%0d exp=8", acc);
        end
        for (int i = 0; i < 30 && SweepBusy !== 1'b1; i++) @(negedge Clk);
        vectorCount++;
        if (SweepBusy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL sweep_busy_rise got=%b exp=1", SweepBusy);
        end
    endtask

    task automatic test_double_sweep();
        int acc;
        pushUpdates(8, acc);
        vectorCount++;
        if (acc != 8) begin
            missCount++;
            $display("[TB] FAIL second_pushes got=%0d exp=8", acc);
        end
        for (int i = 0; i < 100 && (sweepWrites < 16 || updQ.size() != 0); i++) @(negedge Clk);
        vectorCount++;
        if (sweepWrites != 16 || updQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL double_sweep writes=%0d exp=16 upd_left=%0d", sweepWrites, updQ.size());
        end
        repeat (3) @(negedge Clk);
        vectorCount++;
        if (SweepBusy !== 1'b0 || sweepWrites != 16) begin
            missCount++;
            $display("[TB] FAIL sweep_settle busy=%b writes=%0d exp=0/16", SweepBusy, sweepWrites);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int acc;
        int ups;
        int accesses;
        logic r, u;
        doReset();
        pushUpdates(8, acc);
        for (int i = 0; i < 60 && sweepWrites < 4; i++) @(negedge Clk);
        vectorCount++;
        if (sweepWrites != 4) begin
            missCount++;
            $display("[TB] FAIL sweep_reach4 got=%0d exp=4", sweepWrites);
        end
        ups = 0;
        for (int i = 0; i < 10 && ups < 2; i++) begin
            drive(1'b1, 3'd6, 1'b1, 3'(ups + 2), 9'(9'h155 + ups), r, u);
            if (u) ups++;
        end
        @(posedge Clk);
        #3;
        Rest = 1'b1;
        #1;
        vectorCount++;
        if ({BankEn, BankWe, BankAddr, BankDin, BankUClr, SweepBusy} !== 16'd0) begin
            missCount++;
            $display("[TB] FAIL async_reset_outputs got=%h exp=0",
                     {BankEn, BankWe, BankAddr, BankDin, BankUClr, SweepBusy});
        end
        vectorCount++;
        if ({RdReady, UpReady} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL async_reset_readies got=%b exp=00", {RdReady, UpReady});
        end
        readQ.delete();
        updQ.delete();
        sweepWrites = 0;
        expSweep    = 0;
        @(negedge Clk);
        RdReq = 1'b0;
        UpReq = 1'b0;
        @(negedge Clk);
        Rest = 1'b0;
        accesses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            if (BankEn || SweepBusy) accesses++;
        end
        vectorCount++;
        if (accesses != 0) begin
            missCount++;
            $display("[TB] FAIL post_reset_idle accesses=%0d exp=0", accesses);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_update();
        test_back_to_back();
        test_sweep();
        test_double_sweep();
        test_reset_mid_sweep();
        repeat (2) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
